// File: rtl/swchdata_mem_pkg.sv
// rtl/swchdata_mem_pkg.sv - shared types and parity helper for the switch-data memory server
package swchdata_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest data word supported by data_parity; narrower words are zero-extended.
    localparam int PAR_MAXW = 1024;

    function automatic logic data_parity(input logic [PAR_MAXW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/swchdata_mem_server_if.sv
// rtl/swchdata_mem_server_if.sv - clock/reset bundle and two-port FIFO memory interface
interface AXI_clks;
    logic clk;
    logic rst;

    modport to_rtl (input clk, input rst);
    modport to_tb  (output clk, output rst);
endinterface

interface MEMIF_SWCHDATA #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 8
);
    logic [AWIDTH-1:0] f0_waddr;
    logic [DWIDTH-1:0] f0_wdata;
    logic              f0_write;
    logic [AWIDTH-1:0] f0_raddr;
    logic [DWIDTH-1:0] f0_rdata;
    logic [AWIDTH-1:0] f1_waddr;
    logic [DWIDTH-1:0] f1_wdata;
    logic              f1_write;
    logic [AWIDTH-1:0] f1_raddr;
    logic [DWIDTH-1:0] f1_rdata;

    modport to_mem (
        input  f0_waddr, f0_wdata, f0_write, f0_raddr,
        input  f1_waddr, f1_wdata, f1_write, f1_raddr,
        output f0_rdata, f1_rdata
    );

    modport to_fifo (
        output f0_waddr, f0_wdata, f0_write, f0_raddr,
        output f1_waddr, f1_wdata, f1_write, f1_raddr,
        input  f0_rdata, f1_rdata
    );
endinterface

// File: rtl/swchdata_par_bank.sv
// rtl/swchdata_par_bank.sv - one port's storage region with per-entry parity
module swchdata_par_bank
    import swchdata_mem_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              init_mode,
    input  logic [AWIDTH-1:0] clr_addr,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              write,
    input  logic              inj_err,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata,
    output logic              mismatch
);
    localparam int DEPTH = 1 << AWIDTH;

    // Bit DWIDTH of each entry holds the stored parity.
    logic [DWIDTH:0]   mem [DEPTH];
    logic [DWIDTH:0]   rd_word;
    logic [DWIDTH:0]   wr_word;
    logic [AWIDTH-1:0] wr_addr;
    logic              wr_en;

    always_comb begin
        wr_en   = init_mode | write;
        wr_addr = init_mode ? clr_addr : waddr;
        wr_word = init_mode ? '0 : {data_parity(PAR_MAXW'(wdata)) ^ inj_err, wdata};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign rd_word  = mem[raddr];
    assign rdata    = init_mode ? '0 : rd_word[DWIDTH-1:0];
    assign mismatch = ~init_mode &
                      (data_parity(PAR_MAXW'(rd_word[DWIDTH-1:0])) != rd_word[DWIDTH]);

endmodule

// File: rtl/swchdata_mem_server.sv
// rtl/swchdata_mem_server.sv - two-region FIFO memory responder with clearing, parity and write stats
module swchdata_mem_server
    import swchdata_mem_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 8,
    parameter int CWIDTH = 16
) (
    AXI_clks.to_rtl        clks,
    MEMIF_SWCHDATA.to_mem  memif,
    output logic              mem_ready,
    input  logic              err_clr,
    input  logic              inj_err,
    output logic [1:0]        par_err,
    output logic [CWIDTH-1:0] wr_cnt0,
    output logic [CWIDTH-1:0] wr_cnt1
);
    logic              clk;
    logic              resetn;
    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] clr_cnt;
    logic              init_mode;
    logic [1:0]        mismatch;
    logic [1:0]        accept;

    assign clk    = clks.clk;
    assign resetn = clks.rst;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && clr_cnt == '1) begin
            state_nxt = ST_RUN;
        end
    end

    always_comb begin
        init_mode = (state == ST_INIT);
        mem_ready = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clr_cnt <= '0;
        end else if (init_mode) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign accept = {memif.f1_write, memif.f0_write} & {2{~init_mode}};

    swchdata_par_bank #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_bank0 (
        .clk      (clk),
        .init_mode(init_mode),
        .clr_addr (clr_cnt),
        .waddr    (memif.f0_waddr),
        .wdata    (memif.f0_wdata),
        .write    (accept[0]),
        .inj_err  (inj_err),
        .raddr    (memif.f0_raddr),
        .rdata    (memif.f0_rdata),
        .mismatch (mismatch[0])
    );

    swchdata_par_bank #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_bank1 (
        .clk      (clk),
        .init_mode(init_mode),
        .clr_addr (clr_cnt),
        .waddr    (memif.f1_waddr),
        .wdata    (memif.f1_wdata),
        .write    (accept[1]),
        .inj_err  (inj_err),
        .raddr    (memif.f1_raddr),
        .rdata    (memif.f1_rdata),
        .mismatch (mismatch[1])
    );

    // A live mismatch outranks err_clr so a persistent fault is never hidden.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            par_err <= 2'b00;
        end else begin
            par_err <= mismatch | (par_err & ~{2{err_clr}});
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_cnt0 <= '0;
            wr_cnt1 <= '0;
        end else begin
            if (accept[0] && wr_cnt0 != '1) wr_cnt0 <= wr_cnt0 + 1'b1;
            if (accept[1] && wr_cnt1 != '1) wr_cnt1 <= wr_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_swchdata_mem_server.sv
// tb/tb_swchdata_mem_server.sv - self-checking bench for swchdata_mem_server
module tb_swchdata_mem_server;
    localparam int DW    = 64;
    localparam int AW    = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    AXI_clks clks();
    MEMIF_SWCHDATA #(.DWIDTH(DW), .AWIDTH(AW)) memif();

    logic          mem_ready;
    logic          err_clr;
    logic          inj_err;
    logic [1:0]    par_err;
    logic [CW-1:0] wr_cnt0;
    logic [CW-1:0] wr_cnt1;

    swchdata_mem_server #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .clks     (clks),
        .memif    (memif),
        .mem_ready(mem_ready),
        .err_clr  (err_clr),
        .inj_err  (inj_err),
        .par_err  (par_err),
        .wr_cnt0  (wr_cnt0),
        .wr_cnt1  (wr_cnt1)
    );

    initial begin
        clks.clk = 1'b0;
        forever #5 clks.clk = ~clks.clk;
    end

    logic [DW-1:0] m_data [2][DEPTH];
    logic          m_par  [2][DEPTH];
    int            m_cnt  [2];
    logic [1:0]    m_perr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        int            c0;
        int            c1;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_data[p][a] = '0;
                m_par[p][a]  = 1'b0;
            end
            m_cnt[p] = 0;
        end
        m_perr = 2'b00;
    endtask

    // Applies the rules of one RUN-mode clock edge to the reference state.
    task automatic model_edge();
        logic [1:0] mm;
        mm[0] = (^m_data[0][memif.f0_raddr]) != m_par[0][memif.f0_raddr];
        mm[1] = (^m_data[1][memif.f1_raddr]) != m_par[1][memif.f1_raddr];
        m_perr = mm | (m_perr & ~{2{err_clr}});
        if (memif.f0_write) begin
            m_data[0][memif.f0_waddr] = memif.f0_wdata;
            m_par[0][memif.f0_waddr]  = (^memif.f0_wdata) ^ inj_err;
            if (m_cnt[0] < CMAX) m_cnt[0]++;
        end
        if (memif.f1_write) begin
            m_data[1][memif.f1_waddr] = memif.f1_wdata;
            m_par[1][memif.f1_waddr]  = (^memif.f1_wdata) ^ inj_err;
            if (m_cnt[1] < CMAX) m_cnt[1]++;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clks.clk);
        @(negedge clks.clk);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_rdata0"}, memif.f0_rdata, m_data[0][memif.f0_raddr]);
        chk({tag, "_rdata1"}, memif.f1_rdata, m_data[1][memif.f1_raddr]);
        chk({tag, "_par_err"}, 64'(par_err), 64'(m_perr));
        chk({tag, "_wr_cnt0"}, 64'(wr_cnt0), 64'(m_cnt[0]));
        chk({tag, "_wr_cnt1"}, 64'(wr_cnt1), 64'(m_cnt[1]));
    endtask

    task automatic idle_inputs();
        memif.f0_write = 1'b0; memif.f0_waddr = '0; memif.f0_wdata = '0; memif.f0_raddr = '0;
        memif.f1_write = 1'b0; memif.f1_waddr = '0; memif.f1_wdata = '0; memif.f1_raddr = '0;
        err_clr = 1'b0;
        inj_err = 1'b0;
    endtask

    // Reset, then walk the whole clearing phase with f0_write held high.
    task automatic reset_and_init();
        @(negedge clks.clk);
        idle_inputs();
        clks.rst = 1'b0;
        @(posedge clks.clk);
        @(posedge clks.clk);
        @(negedge clks.clk);
        #1;
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        chk("rst_par_err", 64'(par_err), 64'd0);
        chk("rst_wr_cnt0", 64'(wr_cnt0), 64'd0);
        chk("rst_wr_cnt1", 64'(wr_cnt1), 64'd0);
        chk("rst_rdata0", memif.f0_rdata, 64'd0);
        chk("rst_rdata1", memif.f1_rdata, 64'd0);
        model_reset();
        clks.rst = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            memif.f0_write = 1'b1;
            memif.f0_waddr = AW'($urandom);
            memif.f0_wdata = {$urandom, $urandom};
            memif.f0_raddr = AW'($urandom);
            memif.f1_raddr = AW'($urandom);
            #1;
            chk("init_mem_ready", 64'(mem_ready), 64'd0);
            chk("init_rdata0", memif.f0_rdata, 64'd0);
            chk("init_rdata1", memif.f1_rdata, 64'd0);
            @(posedge clks.clk);
            @(negedge clks.clk);
        end
        memif.f0_write = 1'b0;
        #1;
        chk("ready_after_depth", 64'(mem_ready), 64'd1);
        chk("init_wr_cnt0", 64'(wr_cnt0), 64'd0);
        chk("init_par_err", 64'(par_err), 64'd0);
    endtask

    initial begin
        clks.rst = 1'b0;
        idle_inputs();
        model_reset();

        tbl[0] = '{1'b1, 8'd5,   64'hDEAD_BEEF_0000_0001, 1'b0, 8'd5,   64'h0,
                   64'hDEAD_BEEF_0000_0001, 64'h0, 1, 0};
        tbl[1] = '{1'b0, 8'd5,   64'h0,                   1'b1, 8'd5,   64'h1,
                   64'hDEAD_BEEF_0000_0001, 64'h1, 1, 1};
        tbl[2] = '{1'b1, 8'hFF,  64'h0123_4567_89AB_CDEF, 1'b1, 8'hFF,  64'hFFFF_FFFF_FFFF_FFFF,
                   64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2};
        tbl[3] = '{1'b1, 8'h00,  64'h8000_0000_0000_0000, 1'b0, 8'hFF,  64'h0,
                   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3, 2};
        tbl[4] = '{1'b0, 8'd5,   64'h0,                   1'b1, 8'd5,   64'h55,
                   64'hDEAD_BEEF_0000_0001, 64'h55, 3, 3};

        reset_and_init();

        for (int a = 0; a < DEPTH; a++) begin
            memif.f0_raddr = AW'(a);
            memif.f1_raddr = AW'(DEPTH - 1 - a);
            #1;
            chk("clear_rdata0", memif.f0_rdata, 64'd0);
            chk("clear_rdata1", memif.f1_rdata, 64'd0);
            cycle();
        end
        #1;
        chk("clear_par_err", 64'(par_err), 64'd0);

        for (int i = 0; i < 5; i++) begin
            memif.f0_write = tbl[i].w0; memif.f0_waddr = tbl[i].a0;
            memif.f0_wdata = tbl[i].d0; memif.f0_raddr = tbl[i].a0;
            memif.f1_write = tbl[i].w1; memif.f1_waddr = tbl[i].a1;
            memif.f1_wdata = tbl[i].d1; memif.f1_raddr = tbl[i].a1;
            #1;
            cycle();
            memif.f0_write = 1'b0;
            memif.f1_write = 1'b0;
            #1;
            chk("tbl_rdata0", memif.f0_rdata, tbl[i].e0);
            chk("tbl_rdata1", memif.f1_rdata, tbl[i].e1);
            chk("tbl_wr_cnt0", 64'(wr_cnt0), 64'(tbl[i].c0));
            chk("tbl_wr_cnt1", 64'(wr_cnt1), 64'(tbl[i].c1));
            check_outputs("tbl_model");
        end

        // Same-cycle write and read of address 3.
        memif.f0_write = 1'b1; memif.f0_waddr = 8'd3; memif.f0_wdata = 64'hAA; memif.f0_raddr = 8'd3;
        #1;
        cycle();
        memif.f0_wdata = 64'hBB;
        #1;
        chk("rw_same_old", memif.f0_rdata, 64'hAA);
        model_edge();
        @(posedge clks.clk);
        #1;
        chk("rw_same_new", memif.f0_rdata, 64'hBB);
        @(negedge clks.clk);
        memif.f0_write = 1'b0;

        // Injected parity error on port 1, sticky against a blocked clear.
        memif.f1_write = 1'b1; memif.f1_waddr = 8'd7; memif.f1_wdata = 64'h1234; inj_err = 1'b1;
        memif.f1_raddr = 8'd0; memif.f0_raddr = 8'd0;
        #1;
        cycle();
        memif.f1_write = 1'b0; inj_err = 1'b0; memif.f1_raddr = 8'd7;
        #1;
        chk("perr_not_yet", 64'(par_err), 64'd0);
        cycle();
        #1;
        chk("perr_set", 64'(par_err), 64'b10);
        err_clr = 1'b1;
        #1;
        cycle();
        #1;
        chk("perr_clr_blocked", 64'(par_err), 64'b10);
        memif.f1_raddr = 8'd0;
        #1;
        cycle();
        err_clr = 1'b0;
        #1;
        chk("perr_cleared", 64'(par_err), 64'd0);
        check_outputs("perr_model");

        memif.f0_write = 1'b1; memif.f0_waddr = 8'd9; memif.f0_wdata = 64'h99;
        #1;
        cycle();
        memif.f0_write = 1'b0;
        #1;
        chk("pre_reset_wr_cnt0", 64'(wr_cnt0), 64'd6);
        chk("pre_reset_wr_cnt1", 64'(wr_cnt1), 64'd4);

        reset_and_init();
        memif.f0_raddr = 8'd5;
        memif.f1_raddr = 8'd7;
        #1;
        chk("reinit_rdata0", memif.f0_rdata, 64'd0);
        chk("reinit_rdata1", memif.f1_rdata, 64'd0);

        for (int i = 0; i < 20; i++) begin
            memif.f0_write = 1'b1;
            memif.f0_waddr = AW'(i);
            memif.f0_wdata = {$urandom, $urandom};
            #1;
            cycle();
            memif.f0_write = 1'b0;
            #1;
            chk("sat_wr_cnt0", 64'(wr_cnt0), 64'((i + 1 > 15) ? 15 : i + 1));
        end

        for (int i = 0; i < 400; i++) begin
            memif.f0_write = 1'($urandom_range(0, 1));
            memif.f0_waddr = AW'($urandom_range(0, 15));
            memif.f0_wdata = {$urandom, $urandom};
            memif.f0_raddr = AW'($urandom_range(0, 15));
            memif.f1_write = 1'($urandom_range(0, 1));
            memif.f1_waddr = AW'($urandom_range(0, 15));
            memif.f1_wdata = {$urandom, $urandom};
            memif.f1_raddr = AW'($urandom_range(0, 15));
            inj_err = ($urandom_range(0, 15) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            #1;
            check_outputs("rand");
            cycle();
        end
        idle_inputs();
        #1;
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
